// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and branch condition codes.
// Imported by fetch_unit and branch_cond_eval.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] kBrAlways = 2'b00;
  localparam logic [1:0] kBrEq     = 2'b01;
  localparam logic [1:0] kBrNe     = 2'b10;
  localparam logic [1:0] kBrNeg    = 2'b11;

endpackage

// File: rtl/fetch_unit_branch_cond_eval.sv
// Branch condition evaluator: selects the condition named by the instruction's
// condition field from the registered ALU flags.
module branch_cond_eval
  import fetch_unit_pkg::*;
(
  input  logic [1:0] cond_sel_i,
  input  logic       zero_flag_i,
  input  logic       neg_flag_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    unique case (cond_sel_i)
      kBrAlways: cond_o = 1'b1;
      kBrEq:     cond_o = zero_flag_i;
      kBrNe:     cond_o = ~zero_flag_i;
      kBrNeg:    cond_o = neg_flag_i;
      default:   cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch stage with Start/Ack sequencing and branch redirect.
// Define FETCH_INSTR_COUNT_EN to build the saturating retired-instruction counter.
//
//  state | meaning
//  IDLE  | after reset, PC held at 0, waiting for Start
//  ARMED | Start seen, PC held at 0, waiting for Start to drop
//  RUN   | fetching one instruction per cycle
//  DONE  | halt retired, PC frozen, Done high
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              ConditionalJump,
  input  logic              BranchAbsOrRel,
  input  logic [1:0]        BranchConditions,
  input  logic [DATA_W-1:0] Target,
  input  logic              ZeroFlag,
  input  logic              NegFlag,
  input  logic              Ack,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Done,
  output logic [15:0]       InstrCount
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            cond;
  logic            taken;
  logic [PC_W-1:0] branch_pc;

  branch_cond_eval u_cond (
    .cond_sel_i  (BranchConditions),
    .zero_flag_i (ZeroFlag),
    .neg_flag_i  (NegFlag),
    .cond_o      (cond)
  );

  assign taken = ConditionalJump & cond;

  // Relative targets add a sign-extended offset and wrap modulo 2^PC_W.
  always_comb begin
    if (BranchAbsOrRel)
      branch_pc = pc_q + {{(PC_W-DATA_W){Target[DATA_W-1]}}, Target};
    else
      branch_pc = {{(PC_W-DATA_W){1'b0}}, Target};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = ARMED;
      ARMED:   if (!Start) state_d = RUN;
      RUN: begin
        if (Start)    state_d = ARMED;
        else if (Ack) state_d = DONE;
      end
      DONE:    if (Start) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Ack decodes as a branch opcode too, so it must be checked ahead of taken.
  always_comb begin
    pc_d   = pc_q;
    done_d = (state_d == DONE);
    unique case (state_q)
      IDLE, ARMED: pc_d = '0;
      RUN: begin
        if (Start)      pc_d = '0;
        else if (Ack)   pc_d = pc_q;
        else if (taken) pc_d = branch_pc;
        else            pc_d = pc_q + 1'b1;
      end
      DONE:    if (Start) pc_d = '0;
      default: pc_d = '0;
    endcase
  end

  assign ProgCtr = pc_q;
  assign Done    = done_q;

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ARMED)
      cnt_d = '0;
    else if (state_q == RUN && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign InstrCount = cnt_q;
`else
  assign InstrCount = 16'h0000;
`endif

endmodule
